// File: rtl/rv_pkg.sv
// Shared RV definitions: data width, writeback result-select encodings, x0 index.
package rv_pkg;

   localparam int XLEN = 32;

   localparam logic [2:0] RES_ALU  = 3'b000;
   localparam logic [2:0] RES_MEM  = 3'b001;
   localparam logic [2:0] RES_PC4  = 3'b010;
   localparam logic [2:0] RES_UIMM = 3'b011;

   localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/wb_stage_regfile_if.sv
// W-stage bus into the writeback/register-file block, plus the decode read
// ports and status outputs. master = pipeline/decode side, slave = regfile block.
interface wb_stage_regfile_if #(
   parameter int CNT_W = 64
);
   import rv_pkg::*;

   logic               reg_writeW;
   logic [2:0]         result_scrW;
   logic [4:0]         rdW;
   logic [XLEN-1:0]    alu_resultW;
   logic [XLEN-1:0]    read_data_w;
   logic [XLEN-1:0]    PC_PLUS4W;
   logic [XLEN-1:0]    Utype_res_W;
   logic               retire_w;
   logic [4:0]         rs1_D;
   logic [4:0]         rs2_D;
   logic [XLEN-1:0]    rd1_D;
   logic [XLEN-1:0]    rd2_D;
   logic [XLEN-1:0]    result_W;
   logic [CNT_W-1:0]   instret;
   logic [4:0]         last_wr_addr;
   logic [XLEN-1:0]    last_wr_data;

   modport master (
      output reg_writeW, result_scrW, rdW, alu_resultW, read_data_w,
             PC_PLUS4W, Utype_res_W, retire_w, rs1_D, rs2_D,
      input  rd1_D, rd2_D, result_W, instret, last_wr_addr, last_wr_data
   );

   modport slave (
      input  reg_writeW, result_scrW, rdW, alu_resultW, read_data_w,
             PC_PLUS4W, Utype_res_W, retire_w, rs1_D, rs2_D,
      output rd1_D, rd2_D, result_W, instret, last_wr_addr, last_wr_data
   );

endinterface

// File: rtl/wb_stage_regfile_regfile_2r1w.sv
// Two-read one-write integer register file, x0 hard-wired to zero.
// Optional feature macro: WB_BYPASS_EN -- when defined, a read of the register
// being written this cycle returns the write data (write-through).
module regfile_2r1w
   import rv_pkg::*;
#(
   parameter int NREGS = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            we,
   input  logic [4:0]      waddr,
   input  logic [XLEN-1:0] wdata,
   input  logic [4:0]      raddr1,
   input  logic [4:0]      raddr2,
   output logic [XLEN-1:0] rdata1,
   output logic [XLEN-1:0] rdata2
);

   logic [XLEN-1:0] regs [NREGS];
   logic            wr_en;

   assign wr_en = we && (waddr != REG_X0);

   // Storage: clear everything on reset, commit non-x0 writes on the edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (wr_en) begin
         regs[waddr] <= wdata;
      end
   end

`ifdef WB_BYPASS_EN
   // Write-through: same-cycle write data wins over the stored value.
   assign rdata1 = (raddr1 == REG_X0) ? '0 :
                   (wr_en && raddr1 == waddr) ? wdata : regs[raddr1];
   assign rdata2 = (raddr2 == REG_X0) ? '0 :
                   (wr_en && raddr2 == waddr) ? wdata : regs[raddr2];
`else
   // Plain asynchronous read; the new value appears after the edge.
   assign rdata1 = (raddr1 == REG_X0) ? '0 : regs[raddr1];
   assign rdata2 = (raddr2 == REG_X0) ? '0 : regs[raddr2];
`endif

endmodule

// File: rtl/wb_stage_regfile.sv
// Writeback stage: result select, register-file commit, retired-instruction
// counter and last-committed-write capture.
// Optional feature macro: WB_BYPASS_EN (W->D write-through in regfile_2r1w).
module wb_stage_regfile
   import rv_pkg::*;
#(
   parameter int NREGS = 32,
   parameter int CNT_W = 64
) (
   input  logic                 clk,
   input  logic                 reset,
   wb_stage_regfile_if.slave    wb
);

   logic [XLEN-1:0]  result_w;
   logic [CNT_W-1:0] instret_q;
   logic [4:0]       last_addr_q;
   logic [XLEN-1:0]  last_data_q;
   logic             commit;

   assign commit = wb.reg_writeW && (wb.rdW != REG_X0);

   // Writeback result select; unused encodings produce zero.
   always_comb begin
      result_w = '0;
      case (wb.result_scrW)
         RES_ALU:  result_w = wb.alu_resultW;
         RES_MEM:  result_w = wb.read_data_w;
         RES_PC4:  result_w = wb.PC_PLUS4W;
         RES_UIMM: result_w = wb.Utype_res_W;
         default:  result_w = '0;
      endcase
   end

   regfile_2r1w #(.NREGS(NREGS)) u_rf (
      .clk    (clk),
      .reset  (reset),
      .we     (wb.reg_writeW),
      .waddr  (wb.rdW),
      .wdata  (result_w),
      .raddr1 (wb.rs1_D),
      .raddr2 (wb.rs2_D),
      .rdata1 (wb.rd1_D),
      .rdata2 (wb.rd2_D)
   );

   // Retired-instruction counter; wraps silently.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)           instret_q <= '0;
      else if (wb.retire_w) instret_q <= instret_q + 1'b1;
   end

   // Capture the last write that actually changed a register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_addr_q <= '0;
         last_data_q <= '0;
      end else if (commit) begin
         last_addr_q <= wb.rdW;
         last_data_q <= result_w;
      end
   end

   assign wb.result_W     = result_w;
   assign wb.instret      = instret_q;
   assign wb.last_wr_addr = last_addr_q;
   assign wb.last_wr_data = last_data_q;

endmodule

// File: tb/tb_wb_stage_regfile.sv
// Directed bench for wb_stage_regfile: vector table plus hand-written
// sequences for bypass, counter wrap and asynchronous reset.
module tb_wb_stage_regfile;

   logic clk;
   logic reset;
   int   n_vec;
   int   n_bad;
   logic [63:0] exp_instret;

   wb_stage_regfile_if #(.CNT_W(64)) wb_if ();

   wb_stage_regfile dut (
      .clk   (clk),
      .reset (reset),
      .wb    (wb_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [2:0]  sel;
      logic [4:0]  rd;
      logic [31:0] alu;
      logic [31:0] load;
      logic [31:0] pc4;
      logic [31:0] uimm;
      logic        retire;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] e_result;
      logic [31:0] e_rd1;
      logic [31:0] e_rd2;
      logic [4:0]  e_laddr;
      logic [31:0] e_ldata;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      wb_if.reg_writeW  = v.we;
      wb_if.result_scrW = v.sel;
      wb_if.rdW         = v.rd;
      wb_if.alu_resultW = v.alu;
      wb_if.read_data_w = v.load;
      wb_if.PC_PLUS4W   = v.pc4;
      wb_if.Utype_res_W = v.uimm;
      wb_if.retire_w    = v.retire;
      wb_if.rs1_D       = v.rs1;
      wb_if.rs2_D       = v.rs2;
   endtask

   task automatic idle();
      wb_if.reg_writeW = 1'b0;
      wb_if.retire_w   = 1'b0;
   endtask

   initial begin
      n_vec = 0;
      n_bad = 0;
      exp_instret = '0;

      //          we sel  rd  alu           load          pc4       uimm          ret rs1 rs2 result        rd1           rd2           la  ld
      vecs[0] = '{1'b1, 3'd0, 5'd5,  32'hDEADBEEF, 32'h00001234, 32'h104, 32'h12345000, 1'b1, 5'd5,  5'd0,
                  32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        5'd5,  32'hDEADBEEF};
      vecs[1] = '{1'b1, 3'd1, 5'd0,  32'h0,        32'h00001234, 32'h0,   32'h0,        1'b1, 5'd5,  5'd0,
                  32'h00001234, 32'hDEADBEEF, 32'h0,        5'd5,  32'hDEADBEEF};
      vecs[2] = '{1'b1, 3'd2, 5'd1,  32'h1,        32'h2,        32'h104, 32'h3,        1'b0, 5'd1,  5'd5,
                  32'h00000104, 32'h00000104, 32'hDEADBEEF, 5'd1,  32'h00000104};
      vecs[3] = '{1'b1, 3'd3, 5'd2,  32'h1,        32'h2,        32'h3,   32'h12345000, 1'b1, 5'd1,  5'd2,
                  32'h12345000, 32'h00000104, 32'h12345000, 5'd2,  32'h12345000};
      vecs[4] = '{1'b1, 3'd5, 5'd3,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFF, 32'hFFFF,     1'b0, 5'd3,  5'd2,
                  32'h0,        32'h0,        32'h12345000, 5'd3,  32'h0};
      vecs[5] = '{1'b0, 3'd0, 5'd5,  32'h00001111, 32'h0,        32'h0,   32'h0,        1'b1, 5'd5,  5'd5,
                  32'h00001111, 32'hDEADBEEF, 32'hDEADBEEF, 5'd3,  32'h0};
      vecs[6] = '{1'b1, 3'd7, 5'd5,  32'h55555555, 32'h66666666, 32'h7,   32'h8,        1'b1, 5'd5,  5'd1,
                  32'h0,        32'h0,        32'h00000104, 5'd5,  32'h0};
      vecs[7] = '{1'b1, 3'd1, 5'd31, 32'h1,        32'hCAFEF00D, 32'h2,   32'h3,        1'b1, 5'd31, 5'd31,
                  32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 5'd31, 32'hCAFEF00D};

      reset = 1'b0;
      drive(vecs[0]);
      idle();
      wb_if.rs1_D = 5'd0;
      wb_if.rs2_D = 5'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("reset_instret", wb_if.instret, 64'h0);
      chk("reset_last_addr", {59'h0, wb_if.last_wr_addr}, 64'h0);
      chk("reset_last_data", {32'h0, wb_if.last_wr_data}, 64'h0);

      // Table vectors: result_W is combinational before the edge, the rest after.
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         drive(vecs[i]);
         #1;
         chk($sformatf("v%0d_result", i), {32'h0, wb_if.result_W}, {32'h0, vecs[i].e_result});
         @(posedge clk);
         if (vecs[i].retire) exp_instret = exp_instret + 1;
         #1;
         chk($sformatf("v%0d_rd1", i), {32'h0, wb_if.rd1_D}, {32'h0, vecs[i].e_rd1});
         chk($sformatf("v%0d_rd2", i), {32'h0, wb_if.rd2_D}, {32'h0, vecs[i].e_rd2});
         chk($sformatf("v%0d_last_addr", i), {59'h0, wb_if.last_wr_addr}, {59'h0, vecs[i].e_laddr});
         chk($sformatf("v%0d_last_data", i), {32'h0, wb_if.last_wr_data}, {32'h0, vecs[i].e_ldata});
         chk($sformatf("v%0d_instret", i), wb_if.instret, exp_instret);
      end

      // Same-cycle write and read of x7 (old value 0).
      @(negedge clk);
      wb_if.reg_writeW  = 1'b1;
      wb_if.result_scrW = 3'd0;
      wb_if.rdW         = 5'd7;
      wb_if.alu_resultW = 32'hA5A5A5A5;
      wb_if.retire_w    = 1'b0;
      wb_if.rs1_D       = 5'd7;
      wb_if.rs2_D       = 5'd7;
      #1;
`ifdef WB_BYPASS_EN
      chk("bypass_rd1", {32'h0, wb_if.rd1_D}, 64'hA5A5A5A5);
      chk("bypass_rd2", {32'h0, wb_if.rd2_D}, 64'hA5A5A5A5);
`else
      chk("bypass_rd1", {32'h0, wb_if.rd1_D}, 64'h0);
      chk("bypass_rd2", {32'h0, wb_if.rd2_D}, 64'h0);
`endif
      @(posedge clk);
      #1;
      chk("x7_after_edge", {32'h0, wb_if.rd1_D}, 64'hA5A5A5A5);

      // Counter wrap from all-ones.
      @(negedge clk);
      idle();
      force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
      #1;
      release dut.instret_q;
      #1;
      chk("instret_forced", wb_if.instret, 64'hFFFF_FFFF_FFFF_FFFF);
      wb_if.retire_w = 1'b1;
      @(posedge clk);
      #1;
      chk("instret_wrap", wb_if.instret, 64'h0);

      // Ten retire cycles interleaved with three idle cycles, write enable off.
      for (int c = 0; c < 13; c++) begin
         @(negedge clk);
         wb_if.reg_writeW = 1'b0;
         wb_if.retire_w   = (c == 3 || c == 7 || c == 10) ? 1'b0 : 1'b1;
      end
      @(negedge clk);
      idle();
      chk("instret_plus10", wb_if.instret, 64'd10);

      // Asynchronous reset mid-cycle with a write pending.
      wb_if.reg_writeW  = 1'b1;
      wb_if.result_scrW = 3'd0;
      wb_if.rdW         = 5'd9;
      wb_if.alu_resultW = 32'h0BADF00D;
      wb_if.retire_w    = 1'b1;
      wb_if.rs1_D       = 5'd31;
      wb_if.rs2_D       = 5'd5;
      #1;
      reset = 1'b0;
      #1;
      chk("async_rst_rd1", {32'h0, wb_if.rd1_D}, 64'h0);
      chk("async_rst_rd2", {32'h0, wb_if.rd2_D}, 64'h0);
      chk("async_rst_instret", wb_if.instret, 64'h0);
      chk("async_rst_last_addr", {59'h0, wb_if.last_wr_addr}, 64'h0);
      chk("async_rst_last_data", {32'h0, wb_if.last_wr_data}, 64'h0);
      @(posedge clk);
      #1;
      wb_if.rs1_D = 5'd9;
      #1;
      chk("held_rst_no_write", {32'h0, wb_if.rd1_D}, 64'h0);
      chk("held_rst_instret", wb_if.instret, 64'h0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_write", {32'h0, wb_if.rd1_D}, 64'h0BADF00D);
      chk("post_rst_last_addr", {59'h0, wb_if.last_wr_addr}, 64'd9);
      chk("post_rst_instret", wb_if.instret, 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
